// File: rtl/if_id_stall_ctrl_pkg.sv
// Shared front-end definitions for the 5-stage MIPS core: state encoding,
// instruction width, NOP encoding and the fetch PC increment.
package if_id_stall_ctrl_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_ENC = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_LDSTALL = 2'd2;
  localparam logic [1:0] ST_MEMWAIT = 2'd3;

  // Modular increment: the carry out of bit 31 is intentionally dropped.
  function automatic logic [INST_W-1:0] pc_plus4(input logic [INST_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_stall_ctrl_pipe_reg.sv
// Generic pipeline register: synchronous active-low reset, hold enable and a
// flush-load value that takes precedence over a normal capture.
module pipe_reg_en #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic [W-1:0] flush_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of always_ff evaluation order.
  always_ff @(posedge clk_i) begin
    if (!rst_i)       q_q <= RST_VAL;
    else if (flush_i) q_q <= flush_val_i;
    else if (en_i)    q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID pipeline register with the stall/flush sequencer that decides PC
// advance, IF/ID capture/hold/flush and ID/EX bubble; plus a stall counter.
module if_id_stall_ctrl
  import if_id_stall_ctrl_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_ENC,
  parameter int                CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              hazard_stall_i,
  input  logic              flush_i,
  input  logic              mem_busy_i,
  input  logic [INST_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              pc_write_o,
  output logic              id_ex_bubble_o,
  output logic [INST_W-1:0] if_id_pc_o,
  output logic [INST_W-1:0] if_id_inst_o,
  output logic              if_id_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_eval;
  logic             load;
  logic             squash;

  // MEMWAIT with memory released is evaluated exactly like RUN.
  assign run_eval = (state_q == ST_RUN) || (state_q == ST_LDSTALL) ||
                    ((state_q == ST_MEMWAIT) && !mem_busy_i);

  // NOTE: every always_comb output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pc_write_o     = 1'b0;
    id_ex_bubble_o = 1'b0;
    load           = 1'b0;
    squash         = 1'b0;
    state_d        = state_q;
    if (run_eval) begin
      if (mem_busy_i) begin
        state_d = ST_MEMWAIT;
      end else if (flush_i) begin
        pc_write_o = 1'b1;
        squash     = 1'b1;
        state_d    = ST_RUN;
      end else if (hazard_stall_i) begin
        id_ex_bubble_o = 1'b1;
        state_d        = ST_LDSTALL;
      end else begin
        pc_write_o = 1'b1;
        load       = 1'b1;
        state_d    = ST_RUN;
      end
    end else if ((state_q == ST_IDLE) && start_i) begin
      state_d = ST_RUN;
    end
    if (!start_i) state_d = ST_IDLE;
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != ST_IDLE) && !pc_write_o && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: only control state is reset here; the IF/ID datapath registers
  // get their defined reset values inside pipe_reg_en.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

  pipe_reg_en #(.W(INST_W), .RST_VAL(NOP_INST)) u_inst_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (load),
    .flush_i     (squash),
    .flush_val_i (NOP_INST),
    .d_i         (inst_i),
    .q_o         (if_id_inst_o)
  );

  // A flush leaves the PC field untouched, so it only ever captures.
  pipe_reg_en #(.W(INST_W), .RST_VAL('0)) u_pc_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (load),
    .flush_i     (1'b0),
    .flush_val_i ({INST_W{1'b0}}),
    .d_i         (pc_plus4(pc_i)),
    .q_o         (if_id_pc_o)
  );

  pipe_reg_en #(.W(1), .RST_VAL(1'b0)) u_valid_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (load),
    .flush_i     (squash),
    .flush_val_i (1'b0),
    .d_i         (1'b1),
    .q_o         (if_id_valid_o)
  );

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Directed self-checking bench for if_id_stall_ctrl; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_if_id_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, hazard, flush, busy;
  logic [31:0] pc, inst;

  logic        pw, bub, valid;
  logic [31:0] id_pc, id_inst;
  logic [15:0] cnt;

  logic        s_pw, s_bub, s_valid;
  logic [31:0] s_pc, s_inst;
  logic [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  always #5 clk = ~clk;

  if_id_stall_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .hazard_stall_i(hazard),
    .flush_i(flush), .mem_busy_i(busy), .pc_i(pc), .inst_i(inst),
    .pc_write_o(pw), .id_ex_bubble_o(bub), .if_id_pc_o(id_pc),
    .if_id_inst_o(id_inst), .if_id_valid_o(valid), .stall_cnt_o(cnt)
  );

  if_id_stall_ctrl #(.CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .hazard_stall_i(hazard),
    .flush_i(flush), .mem_busy_i(busy), .pc_i(pc), .inst_i(inst),
    .pc_write_o(s_pw), .id_ex_bubble_o(s_bub), .if_id_pc_o(s_pc),
    .if_id_inst_o(s_inst), .if_id_valid_o(s_valid), .stall_cnt_o(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; hazard = 1'b0; flush = 1'b0; busy = 1'b0;
    pc = 32'h0; inst = 32'hDEAD_BEEF;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (id_inst !== NOP) begin errors++; $display("FAIL reset_inst got=%h exp=%h", id_inst, NOP); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++; if (pw !== 1'b0 || bub !== 1'b0) begin errors++; $display("FAIL idle_ctrl got pw=%b bub=%b exp 0 0", pw, bub); end
    tick();
    checks++; if (id_inst !== NOP || valid !== 1'b0) begin errors++; $display("FAIL idle_hold got inst=%h valid=%b exp NOP 0", id_inst, valid); end
  endtask

  task automatic test_fetch();
    start = 1'b1; inst = 32'h8C22_0004; pc = 32'h0000_0010;
    tick();
    checks++; if (pw !== 1'b1 || bub !== 1'b0) begin errors++; $display("FAIL fetch_ctrl got pw=%b bub=%b exp 1 0", pw, bub); end
    tick();
    checks++; if (id_inst !== 32'h8C22_0004) begin errors++; $display("FAIL fetch_inst got=%h exp=8c220004", id_inst); end
    checks++; if (id_pc !== 32'h0000_0014) begin errors++; $display("FAIL fetch_pc got=%h exp=00000014", id_pc); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got=%b exp=1", valid); end
  endtask

  task automatic test_hazard();
    inst = 32'h1111_1111; pc = 32'h0000_0020; hazard = 1'b1;
    #1;
    checks++; if (pw !== 1'b0 || bub !== 1'b1) begin errors++; $display("FAIL hazard_ctrl got pw=%b bub=%b exp 0 1", pw, bub); end
    tick();
    checks++; if (id_inst !== 32'h8C22_0004 || id_pc !== 32'h0000_0014) begin errors++; $display("FAIL hazard_hold got inst=%h pc=%h exp 8c220004 00000014", id_inst, id_pc); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL hazard_cnt got=%0d exp=1", cnt); end
    hazard = 1'b0;
    #1;
    checks++; if (pw !== 1'b1 || bub !== 1'b0) begin errors++; $display("FAIL ldstall_resume got pw=%b bub=%b exp 1 0", pw, bub); end
    tick();
    checks++; if (id_inst !== 32'h1111_1111 || id_pc !== 32'h0000_0024) begin errors++; $display("FAIL resume_capture got inst=%h pc=%h exp 11111111 00000024", id_inst, id_pc); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL resume_cnt got=%0d exp=1", cnt); end
  endtask

  task automatic test_flush();
    inst = 32'h2222_2222; pc = 32'h0000_0030; flush = 1'b1; hazard = 1'b1;
    #1;
    checks++; if (pw !== 1'b1 || bub !== 1'b0) begin errors++; $display("FAIL flush_ctrl got pw=%b bub=%b exp 1 0", pw, bub); end
    tick();
    flush = 1'b0; hazard = 1'b0;
    checks++; if (id_inst !== NOP || valid !== 1'b0) begin errors++; $display("FAIL flush_squash got inst=%h valid=%b exp NOP 0", id_inst, valid); end
    checks++; if (id_pc !== 32'h0000_0024) begin errors++; $display("FAIL flush_pc got=%h exp=00000024", id_pc); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt got=%0d exp=1", cnt); end
  endtask

  task automatic test_pc_wrap();
    inst = 32'h3333_3333; pc = 32'hFFFF_FFFC;
    tick();
    checks++; if (id_pc !== 32'h0 || valid !== 1'b1 || id_inst !== 32'h3333_3333) begin errors++; $display("FAIL pc_wrap got pc=%h valid=%b inst=%h exp 00000000 1 33333333", id_pc, valid, id_inst); end
  endtask

  task automatic test_memwait();
    inst = 32'h4444_4444; pc = 32'h0000_0040; busy = 1'b1; hazard = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pw !== 1'b0 || bub !== 1'b0) begin errors++; $display("FAIL memwait_ctrl[%0d] got pw=%b bub=%b exp 0 0", i, pw, bub); end
      tick();
    end
    checks++; if (id_inst !== 32'h3333_3333 || id_pc !== 32'h0) begin errors++; $display("FAIL memwait_hold got inst=%h pc=%h exp 33333333 00000000", id_inst, id_pc); end
    checks++; if (cnt !== 16'd4) begin errors++; $display("FAIL memwait_cnt got=%0d exp=4", cnt); end
    busy = 1'b0;
    #1;
    checks++; if (pw !== 1'b0 || bub !== 1'b1) begin errors++; $display("FAIL memwait_release got pw=%b bub=%b exp 0 1", pw, bub); end
    tick();
    hazard = 1'b0;
    checks++; if (cnt !== 16'd5) begin errors++; $display("FAIL release_cnt got=%0d exp=5", cnt); end
    tick();
    checks++; if (id_inst !== 32'h4444_4444 || id_pc !== 32'h0000_0044) begin errors++; $display("FAIL post_stall_capture got inst=%h pc=%h exp 44444444 00000044", id_inst, id_pc); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_sat;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    hazard = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (bub !== 1'b1 || s_pw !== 1'b0) begin errors++; $display("FAIL b2b_ctrl[%0d] got bub=%b pw=%b exp 1 0", i, bub, s_pw); end
      tick();
      exp_sat = (i >= 2) ? 2'b11 : 2'(i + 1);
      checks++; if (s_cnt !== exp_sat) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, s_cnt, exp_sat); end
    end
    hazard = 1'b0;
    checks++; if (cnt !== 16'd6) begin errors++; $display("FAIL b2b_cnt got=%0d exp=6", cnt); end
  endtask

  task automatic test_reset_memwait();
    busy = 1'b1;
    tick();
    checks++; if (cnt !== 16'd7) begin errors++; $display("FAIL pre_reset_cnt got=%0d exp=7", cnt); end
    rst = 1'b0;
    tick();
    checks++; if (id_inst !== NOP || valid !== 1'b0 || id_pc !== 32'h0) begin errors++; $display("FAIL midstall_reset_ifid got inst=%h valid=%b pc=%h exp NOP 0 0", id_inst, valid, id_pc); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL midstall_reset_cnt got=%0d exp=0", cnt); end
    rst = 1'b1;
    #1;
    checks++; if (pw !== 1'b0 || bub !== 1'b0) begin errors++; $display("FAIL midstall_reset_idle got pw=%b bub=%b exp 0 0", pw, bub); end
    busy = 1'b0; start = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_hazard();
    test_flush();
    test_pc_wrap();
    test_memwait();
    test_back_to_back();
    test_reset_memwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_stall_ctrl.md
Name: if_id_stall_ctrl

Overview:
- IF/ID pipeline register plus stall/flush sequencer. It consumes the load-use stall request from the hazard detection unit, the branch/jump flush from ID and the data-memory busy from MEM.
- Decides per cycle whether the PC advances, whether IF/ID captures, holds or is flushed, and whether ID/EX receives a bubble.
- Sits between the fetch stage (PC, instruction memory) and the decode stage of the 5-stage MIPS CPU. Keeps a saturating stall-cycle counter for debug.

Parameters:
- NOP_INST, 32'h0000_0000, instruction word loaded into IF/ID on flush or reset.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous reset, active-low.
- start_i  in  1  CPU run enable; low holds the block in IDLE.
- hazard_stall_i  in  1  load-use stall request from the hazard detection unit.
- flush_i  in  1  branch/jump taken in ID; discard the instruction being fetched.
- mem_busy_i  in  1  data memory not ready; freeze the whole front end.
- pc_i  in  32  PC of the instruction currently in IF.
- inst_i  in  32  instruction word from instruction memory.
- pc_write_o  out  1  PC register write enable.
- id_ex_bubble_o  out  1  force ID/EX control fields to zero.
- if_id_pc_o  out  32  registered PC+4 of the instruction in ID.
- if_id_inst_o  out  32  registered instruction in ID.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_write_o = 0 while running.

Behaviour:
- Clock is clk_i. Reset is synchronous, active-low on rst_i; sampled only at the rising edge.
- Reset values: state IDLE, if_id_inst_o = NOP_INST, if_id_pc_o = 0, if_id_valid_o = 0, stall_cnt_o = 0. pc_write_o = 0 and id_ex_bubble_o = 0 while in IDLE.
- pc_write_o and id_ex_bubble_o are combinational from the current state and inputs, so a stall takes effect in the same cycle it is requested. All IF/ID fields are registered (1-cycle latency).
- States:
  - IDLE: outputs held. Goes to RUN when start_i = 1.
  - RUN: normal operation.
  - LDSTALL: one-cycle load-use hold.
  - MEMWAIT: frozen until mem_busy_i = 0.
- Priority in RUN, highest first: mem_busy_i > flush_i > hazard_stall_i > normal.
  - mem_busy_i = 1: pc_write_o = 0, bubble = 0, IF/ID holds, next = MEMWAIT.
  - flush_i = 1: pc_write_o = 1, bubble = 0, IF/ID <= {NOP_INST, valid 0, pc unchanged}, stay in RUN.
  - hazard_stall_i = 1: pc_write_o = 0, bubble = 1, IF/ID holds, next = LDSTALL.
  - Otherwise: pc_write_o = 1, IF/ID <= {inst_i, pc_i + 4, valid 1}.
- LDSTALL: treated exactly as RUN for this cycle, including a new hazard_stall_i, which re-enters LDSTALL. Back-to-back load-use stalls are therefore allowed.
- MEMWAIT:
  - While mem_busy_i = 1: all outputs frozen, bubble = 0.
  - When mem_busy_i falls: same cycle evaluated as RUN, and the state returns to RUN.
  - A flush_i or hazard_stall_i that arrives during MEMWAIT is ignored until mem_busy_i = 0. The ID and MEM stages re-assert those requests because their stage contents are also frozen.
- Flush and hazard in the same cycle: flush wins. The hazarding instruction is squashed, so no bubble is issued.
- start_i deasserted in any state: next = IDLE. IF/ID is not cleared.
- stall_cnt_o: +1 on every non-IDLE cycle with pc_write_o = 0. Saturates at all-ones with no wrap. Cleared only by reset.
- PC+4 is 32-bit modular; the carry is discarded (pc_i = 32'hFFFF_FFFC gives 0).
- Reset mid-stall: wins unconditionally, and the next cycle starts in IDLE.

Decomposition:
- Shared CPU package holds:
  - state encoding (IDLE = 2'd0, RUN = 2'd1, LDSTALL = 2'd2, MEMWAIT = 2'd3);
  - the NOP encoding;
  - the instruction width constant.
- One natural sub-module, pipe_reg_en: a width-parameterised register with sync active-low reset, hold enable and flush-load value. It is used for the IF/ID fields and is reusable for the other pipeline registers.

Test Plan:
- Reset then start_i = 1, inst_i = 32'h8C22_0004, pc_i = 32'h0000_0010 → next cycle if_id_inst_o = 32'h8C22_0004, if_id_pc_o = 32'h0000_0014, valid = 1, pc_write_o = 1.
- hazard_stall_i = 1 for one cycle → same cycle pc_write_o = 0, id_ex_bubble_o = 1; IF/ID unchanged; stall_cnt_o = 1 afterwards; RUN resumes next cycle.
- flush_i = 1 together with hazard_stall_i = 1 → pc_write_o = 1, bubble = 0; next cycle if_id_inst_o = NOP_INST, valid = 0.
- mem_busy_i = 1 for 3 cycles while hazard_stall_i = 1 → pc_write_o = 0 and bubble = 0 throughout; stall_cnt_o += 3; the stall is honoured with bubble = 1 on the cycle mem_busy_i falls.
- CNT_W = 2, hold hazard_stall_i = 1 for 6 cycles → stall_cnt_o saturates at 2'b11.
- rst_i = 0 during MEMWAIT → next cycle IDLE, IF/ID = NOP_INST, valid = 0, stall_cnt_o = 0.
